// File: rtl/stream_mux2_arb_pkg.sv
// Shared encodings for the two-input stream arbiter.
// The state and select constants are used by the arbiter FSM and its select logic.
package stream_mux2_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCK_A = 2'd1;
    localparam logic [1:0] ST_LOCK_B = 2'd2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Returns the lock state that keeps the current grant for the rest of a packet.
    function automatic logic [1:0] lock_state(input logic sel);
        return (sel == SEL_B) ? ST_LOCK_B : ST_LOCK_A;
    endfunction

endpackage

// File: rtl/stream_mux2_arb_if.sv
// Stream bundle for the arbiter: two input streams, one merged output, select and busy.
// slave is the arbiter's view; master is the surrounding environment's view.
interface stream_mux2_arb_if #(parameter int WIDTH = 8);

    logic             A_VALID;
    logic [WIDTH-1:0] A_DATA;
    logic             A_LAST;
    logic             A_READY;
    logic             B_VALID;
    logic [WIDTH-1:0] B_DATA;
    logic             B_LAST;
    logic             B_READY;
    logic             Z_VALID;
    logic [WIDTH-1:0] Z_DATA;
    logic             Z_LAST;
    logic             Z_READY;
    logic             S;
    logic             BUSY;

    modport slave (
        input  A_VALID, A_DATA, A_LAST, B_VALID, B_DATA, B_LAST, Z_READY,
        output A_READY, B_READY, Z_VALID, Z_DATA, Z_LAST, S, BUSY
    );

    modport master (
        output A_VALID, A_DATA, A_LAST, B_VALID, B_DATA, B_LAST, Z_READY,
        input  A_READY, B_READY, Z_VALID, Z_DATA, Z_LAST, S, BUSY
    );

endinterface

// File: rtl/stream_mux2_arb_pipe_reg.sv
// Single-entry output register: loads a new word, empties when loaded without one,
// and holds everything while the downstream stalls.
module stream_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         set,
    input  logic [WIDTH:0] d,
    output logic         q_valid,
    output logic [WIDTH:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (load) begin
            q_valid <= set;
            if (set) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/stream_mux2_arb.sv
// Round-robin valid/ready arbiter driving the select of a MUX2 bank, with optional
// per-packet locking on LAST and a registered single-entry output stage.
module stream_mux2_arb
    import stream_mux2_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit LOCK_PKT = 1'b1
) (
    input  logic              CK,
    input  logic              RST,
    stream_mux2_arb_if.slave  bus
);

    logic [1:0]       state;
    logic             pri;
    logic             sel;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             load;
    logic             ready_en;
    logic             xfer;
    logic             z_valid;
    logic [WIDTH:0]   z_word;

    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = SEL_A;
        case (state)
            ST_LOCK_A: sel = SEL_A;
            ST_LOCK_B: sel = SEL_B;
            default:   sel = bus.B_VALID & (~bus.A_VALID | pri);
        endcase
    end

    assign sel_valid = (sel == SEL_B) ? bus.B_VALID : bus.A_VALID;
    assign sel_last  = (sel == SEL_B) ? bus.B_LAST  : bus.A_LAST;
    assign sel_data  = (sel == SEL_B) ? bus.B_DATA  : bus.A_DATA;

    // Nothing is accepted while reset is applied, so no beat is lost into a clearing register.
    assign load     = ~z_valid | bus.Z_READY;
    assign ready_en = load & ~RST;
    assign xfer     = ready_en & sel_valid;

    assign bus.A_READY = ready_en & (sel == SEL_A);
    assign bus.B_READY = ready_en & (sel == SEL_B);
    assign bus.S       = sel;

    always_ff @(posedge CK) begin
        if (RST) begin
            state <= ST_IDLE;
            pri   <= 1'b0;
        end else if (xfer) begin
            if (!LOCK_PKT || sel_last) begin
                state <= ST_IDLE;
                pri   <= ~sel;
            end else begin
                state <= lock_state(sel);
            end
        end
    end

    stream_pipe_reg #(.WIDTH(WIDTH)) u_out (
        .clk     (CK),
        .rst     (RST),
        .load    (load),
        .set     (xfer),
        .d       ({sel_last, sel_data}),
        .q_valid (z_valid),
        .q       (z_word)
    );

    assign bus.Z_VALID = z_valid;
    assign bus.Z_LAST  = z_word[WIDTH];
    assign bus.Z_DATA  = z_word[WIDTH-1:0];
    assign bus.BUSY    = (state == ST_LOCK_A) | (state == ST_LOCK_B) | z_valid;

endmodule

// File: tb/tb_stream_mux2_arb.sv
// Directed bench: a vector table on a packet-locking instance, then a hand-written
// beat-interleave sequence on a per-beat instance.
module tb_stream_mux2_arb;

    logic clk = 1'b0;
    logic rst;
    logic rst0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stream_mux2_arb_if #(.WIDTH(8)) m1 ();
    stream_mux2_arb_if #(.WIDTH(8)) m0 ();

    stream_mux2_arb #(.WIDTH(8), .LOCK_PKT(1'b1)) u_lock (.CK(clk), .RST(rst),  .bus(m1));
    stream_mux2_arb #(.WIDTH(8), .LOCK_PKT(1'b0)) u_beat (.CK(clk), .RST(rst0), .bus(m0));

    typedef struct {
        logic       rst;
        logic       av;
        logic [7:0] ad;
        logic       al;
        logic       bv;
        logic [7:0] bd;
        logic       bl;
        logic       zr;
        logic       s;
        logic       ar;
        logic       br;
        logic       zv;
        logic [7:0] zd;
        logic       zl;
        logic       busy;
        logic       chk_z;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input int rst_i, input int av, input int ad, input int al,
                     input int bv, input int bd, input int bl, input int zr,
                     input int s, input int ar, input int br,
                     input int zv, input int zd, input int zl, input int busy, input int chk_z);
        vec_t r;
        r.rst = rst_i[0]; r.av = av[0]; r.ad = ad[7:0]; r.al = al[0];
        r.bv = bv[0]; r.bd = bd[7:0]; r.bl = bl[0]; r.zr = zr[0];
        r.s = s[0]; r.ar = ar[0]; r.br = br[0];
        r.zv = zv[0]; r.zd = zd[7:0]; r.zl = zl[0]; r.busy = busy[0]; r.chk_z = chk_z[0];
        vecs.push_back(r);
    endtask

    initial begin
        logic [7:0] a_d [2];
        logic [7:0] b_d [2];
        logic       a_l [2];
        logic [7:0] exp_z [4];
        logic       exp_l [4];
        logic       exp_s [4];
        int ai, bi, zi;

        // reset pulse with both valid, then first grant
        //  rst av ad    al bv bd    bl zr  s ar br  zv zd    zl busy chk
        v(1, 1, 'h11, 1, 1, 'h22, 1, 1,  0, 0, 0,  0, 'h00, 0, 0, 1);
        v(0, 1, 'h11, 1, 1, 'h22, 1, 1,  0, 1, 0,  0, 'h00, 0, 0, 1);
        // round robin, single-beat packets
        v(0, 1, 'hA0, 1, 1, 'hB0, 1, 1,  1, 0, 1,  1, 'h11, 1, 1, 1);
        v(0, 1, 'hA0, 1, 1, 'hB1, 1, 1,  0, 1, 0,  1, 'hB0, 1, 1, 1);
        v(0, 1, 'hA1, 1, 1, 'hB1, 1, 1,  1, 0, 1,  1, 'hA0, 1, 1, 1);
        v(0, 1, 'hA1, 1, 0, 'h00, 0, 1,  0, 1, 0,  1, 'hB1, 1, 1, 1);
        v(0, 0, 'h00, 0, 1, 'hE0, 1, 1,  1, 0, 1,  1, 'hA1, 1, 1, 1);
        // A packet 01,02,03 locked against a waiting B (A drops VALID once mid-packet)
        v(0, 1, 'h01, 0, 1, 'hF0, 1, 1,  0, 1, 0,  1, 'hE0, 1, 1, 1);
        v(0, 0, 'h00, 0, 1, 'hF0, 1, 1,  0, 1, 0,  1, 'h01, 0, 1, 1);
        v(0, 1, 'h02, 0, 1, 'hF0, 1, 1,  0, 1, 0,  0, 'h00, 0, 1, 0);
        v(0, 1, 'h03, 1, 1, 'hF0, 1, 1,  0, 1, 0,  1, 'h02, 0, 1, 1);
        v(0, 0, 'h00, 0, 1, 'hF0, 1, 1,  1, 0, 1,  1, 'h03, 1, 1, 1);
        // backpressure holding 0x5A for four cycles
        v(0, 1, 'h5A, 1, 0, 'h00, 0, 1,  0, 1, 0,  1, 'hF0, 1, 1, 1);
        for (int k = 0; k < 4; k++)
            v(0, 1, 'h5B, 1, 1, 'hC0, 1, 0,  1, 0, 0,  1, 'h5A, 1, 1, 1);
        v(0, 1, 'h5B, 1, 1, 'hC0, 1, 1,  1, 0, 1,  1, 'h5A, 1, 1, 1);
        v(0, 1, 'h5B, 1, 0, 'h00, 0, 1,  0, 1, 0,  1, 'hC0, 1, 1, 1);
        v(0, 0, 'h00, 0, 0, 'h00, 0, 1,  0, 1, 0,  1, 'h5B, 1, 1, 1);
        v(0, 0, 'h00, 0, 0, 'h00, 0, 1,  0, 1, 0,  0, 'h00, 0, 0, 0);
        // reset after beat 2 of a 4-beat B packet
        v(0, 0, 'h00, 0, 1, 'hD1, 0, 1,  1, 0, 1,  0, 'h00, 0, 0, 0);
        v(0, 0, 'h00, 0, 1, 'hD2, 0, 1,  1, 0, 1,  1, 'hD1, 0, 1, 1);
        v(1, 1, 'hAA, 1, 1, 'hD3, 0, 1,  1, 0, 0,  1, 'hD2, 0, 1, 1);
        v(0, 1, 'hAA, 1, 1, 'hD3, 0, 1,  0, 1, 0,  0, 'h00, 0, 0, 1);
        v(0, 0, 'h00, 0, 0, 'h00, 0, 1,  0, 1, 0,  1, 'hAA, 1, 1, 1);
        v(0, 0, 'h00, 0, 0, 'h00, 0, 1,  0, 1, 0,  0, 'h00, 0, 0, 0);

        rst = 1'b1; rst0 = 1'b1;
        m1.A_VALID = 1'b0; m1.A_DATA = '0; m1.A_LAST = 1'b0;
        m1.B_VALID = 1'b0; m1.B_DATA = '0; m1.B_LAST = 1'b0; m1.Z_READY = 1'b1;
        m0.A_VALID = 1'b0; m0.A_DATA = '0; m0.A_LAST = 1'b0;
        m0.B_VALID = 1'b0; m0.B_DATA = '0; m0.B_LAST = 1'b0; m0.Z_READY = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst0 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst        = vecs[i].rst;
            m1.A_VALID = vecs[i].av; m1.A_DATA = vecs[i].ad; m1.A_LAST = vecs[i].al;
            m1.B_VALID = vecs[i].bv; m1.B_DATA = vecs[i].bd; m1.B_LAST = vecs[i].bl;
            m1.Z_READY = vecs[i].zr;
            @(negedge clk);
            check($sformatf("row%0d S", i),       32'(m1.S),       32'(vecs[i].s));
            check($sformatf("row%0d A_READY", i), 32'(m1.A_READY), 32'(vecs[i].ar));
            check($sformatf("row%0d B_READY", i), 32'(m1.B_READY), 32'(vecs[i].br));
            check($sformatf("row%0d Z_VALID", i), 32'(m1.Z_VALID), 32'(vecs[i].zv));
            check($sformatf("row%0d BUSY", i),    32'(m1.BUSY),    32'(vecs[i].busy));
            if (vecs[i].chk_z) begin
                check($sformatf("row%0d Z_DATA", i), 32'(m1.Z_DATA), 32'(vecs[i].zd));
                check($sformatf("row%0d Z_LAST", i), 32'(m1.Z_LAST), 32'(vecs[i].zl));
            end
        end

        // per-beat arbitration: two 2-beat packets interleave A,B,A,B
        a_d = '{8'h31, 8'h32}; a_l = '{1'b0, 1'b1};
        b_d = '{8'h41, 8'h42};
        exp_z = '{8'h31, 8'h41, 8'h32, 8'h42};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        ai = 0; bi = 0; zi = 0;
        for (int c = 0; c < 12 && zi < 4; c++) begin
            @(posedge clk);
            #1;
            m0.A_VALID = (ai < 2);
            m0.A_DATA  = (ai < 2) ? a_d[ai] : 8'h00;
            m0.A_LAST  = (ai < 2) ? a_l[ai] : 1'b0;
            m0.B_VALID = (bi < 2);
            m0.B_DATA  = (bi < 2) ? b_d[bi] : 8'h00;
            m0.B_LAST  = (bi < 2) ? a_l[bi] : 1'b0;
            @(negedge clk);
            if (ai + bi < 4)
                check($sformatf("beat S%0d", ai + bi), 32'(m0.S), 32'(exp_s[ai + bi]));
            if (m0.Z_VALID) begin
                check($sformatf("beat Z_DATA%0d", zi), 32'(m0.Z_DATA), 32'(exp_z[zi]));
                check($sformatf("beat Z_LAST%0d", zi), 32'(m0.Z_LAST), 32'(exp_l[zi]));
                zi++;
            end
            if (m0.A_VALID && m0.A_READY) ai++;
            if (m0.B_VALID && m0.B_READY) bi++;
        end
        check("beat count", 32'(zi), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux2_arb.md
Name: stream_mux2_arb

Overview:
- Two-input valid/ready stream arbiter. Drives the select line S of a bank of WIDTH MUX2 cells, which merges streams A and B into one output stream.
- Sits directly upstream of the MUX2 datapath and registers the muxed result into a single-entry output stage.
- Arbitration is round-robin per packet, with optional packet locking via LAST.

Parameters:
- WIDTH, 8, data bits per beat.
- LOCK_PKT, 1. When 1, a grant is held from the first beat to the LAST beat. When 0, arbitration happens per beat.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- A_VALID  in  1  stream A beat valid.
- A_DATA  in  WIDTH  stream A payload.
- A_LAST  in  1  stream A end-of-packet.
- A_READY  out  1  stream A beat accepted when A_VALID&A_READY.
- B_VALID  in  1  stream B beat valid.
- B_DATA  in  WIDTH  stream B payload.
- B_LAST  in  1  stream B end-of-packet.
- B_READY  out  1  stream B accept.
- Z_VALID  out  1  output beat valid (registered).
- Z_DATA  out  WIDTH  output payload (registered).
- Z_LAST  out  1  output end-of-packet (registered).
- Z_READY  in  1  downstream accept.
- S  out  1  mux select, 0=A, 1=B (combinational).
- BUSY  out  1  high when state!=IDLE or Z_VALID.

Behaviour:
- Reset (RST high at a CK edge):
  - state=IDLE, PRI=0 (A favoured), Z_VALID=0, Z_DATA=0, Z_LAST=0.
  - Takes effect mid-packet and mid-stall: held output beat is discarded and any lock is released.
- Internal signal load = !Z_VALID | Z_READY.
- States:
  - IDLE: S = B_VALID & (!A_VALID | PRI).
  - LOCK_A: S=0.
  - LOCK_B: S=1.
- A_READY = load & !S. B_READY = load & S. The ungranted side always sees READY=0.
- Transfer on xfer = granted VALID & granted READY. On that edge:
  - Z_DATA/Z_LAST take the selected input.
  - Z_VALID=1.
  - Latency is one cycle from input handshake to Z_VALID.
- If load and no xfer: Z_VALID=0 on the next edge.
- If !load: Z_VALID, Z_DATA and Z_LAST hold stable (no change while stalled).
- State transitions (LOCK_PKT=1):
  - IDLE, xfer with LAST=0 → LOCK_A or LOCK_B matching S.
  - IDLE, xfer with LAST=1 → stay IDLE; PRI=!S.
  - LOCK_x, xfer with LAST=1 → IDLE; PRI=!S.
  - LOCK_x, otherwise → hold, even if the other side is valid or the granted side drops VALID.
- LOCK_PKT=0: LOCK states are unreachable. Every xfer sets PRI=!S, so both valid alternates A,B,A,B.
- No xfer in IDLE: PRI unchanged.
- Simultaneous events:
  - Z_READY=1 with a new xfer in the same cycle gives full throughput of 1 beat/cycle.
  - Both valid in IDLE → PRI decides.
- Arithmetic: none beyond WIDTH-bit pass-through. No counters overflow.
- Protocol: a VALID, once raised, is assumed held until accepted. The block does not check this; violations are the verification environment's concern.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=2'd0, ST_LOCK_A=2'd1, ST_LOCK_B=2'd2 (2'd3 decodes to IDLE).
  - SEL_A=1'b0, SEL_B=1'b1.
- Sub-module stream_pipe_reg: single-entry WIDTH+1 output register with load/hold/clear. The arbiter FSM and the S/READY logic stay in the top module.

Test Plan:
- Reset: drive A/B valid, pulse RST for 1 cycle.
  - During RST: A_READY=B_READY=0.
  - After RST: Z_VALID=0, Z_DATA=0, BUSY=0.
  - First grant: A_DATA=0x11 appears on Z_DATA one cycle after handshake.
- Round-robin: A and B single-beat (LAST=1), continuously valid, Z_READY=1. A_DATA=0xA0.., B_DATA=0xB0.. → Z_DATA sequence A0,B0,A1,B1; S toggles every cycle.
- Packet lock (LOCK_PKT=1): A 3-beat packet 0x01,0x02,0x03 (LAST on 0x03), B_VALID held high with 0xF0.
  - B_READY=0 for 3 cycles.
  - Z order 01,02,03,F0; Z_LAST=1 on 03.
- Backpressure: Z_READY=0 for 4 cycles with Z_VALID=1, Z_DATA=0x5A.
  - Z_DATA holds 0x5A.
  - A_READY=B_READY=0.
  - On Z_READY=1: next beat accepted the same cycle, no beat lost or duplicated.
- Reset mid-packet: RST after beat 2 of a 4-beat B packet.
  - state IDLE, Z_VALID=0.
  - With both valid next, A wins (PRI=0).
- LOCK_PKT=0: A 2-beat packet and B 2-beat packet, both valid → output interleaves A,B,A,B beat-wise.
